// File: rtl/ssd_scan_if.sv
// ssd_scan_if: bundles the segment/digit signals of ssd_scan_ctrl.
//   master : drives q_7..q_4, load, digit_en; observes ssd, D, scan_idx,
//            frame_tick, load_ack
//   slave  : the scan controller side (directions mirrored)
interface ssd_scan_if;
    logic [7:0] q_7;
    logic [7:0] q_6;
    logic [7:0] q_5;
    logic [7:0] q_4;
    logic       load;
    logic [3:0] digit_en;
    logic [3:0] ssd;
    logic [7:0] D;
    logic [1:0] scan_idx;
    logic       frame_tick;
    logic       load_ack;

    modport master (
        output q_7, q_6, q_5, q_4, load, digit_en,
        input  ssd, D, scan_idx, frame_tick, load_ack
    );

    modport slave (
        input  q_7, q_6, q_5, q_4, load, digit_en,
        output ssd, D, scan_idx, frame_tick, load_ack
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: 4-digit multiplexed seven-segment scan controller with
// frame-synchronous double-buffered pattern loading.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : ssd_scan_if.slave
//          q_7..q_4  segment patterns (active-low) for digits 0..3
//          load      1-cycle capture request
//          digit_en  per-digit enable, bit 3 = digit 0
//          ssd       active-low digit select (registered)
//          D         active-low segment data (registered)
//          scan_idx  digit currently scanned
//          frame_tick 1-cycle pulse after each frame wrap
//          load_ack  1-cycle pulse when loaded data becomes active
// Parameters: SCAN_DIV clk cycles per digit slot, BLANK_CYC blanking cycles
// at slot start.
// Optional feature macro: SSD_SCAN_BLANK_EN enables per-slot blanking.
module ssd_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    ssd_scan_if.slave  bus
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    // Elaboration-time guard on the legal parameter range.
    if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20) || BLANK_CYC >= SCAN_DIV) begin : g_bad_cfg
        $error("ssd_scan_ctrl: illegal SCAN_DIV/BLANK_CYC combination");
    end

    logic [CNT_W-1:0] slot_cnt;
    logic             pending;
    // Index 0 holds digit 0 (q_7), index 3 holds digit 3 (q_4).
    logic [3:0][7:0]  shadow;
    logic [3:0][7:0]  act;

    logic             slot_wrap;
    logic             frame_end;
    logic [3:0]       nxt_ssd;
    logic [7:0]       nxt_d;

    assign slot_wrap = (slot_cnt == CNT_MAX);
    assign frame_end = slot_wrap && (bus.scan_idx == 2'd3);

    // Output pattern for the digit being scanned; registered below.
    always_comb begin
        nxt_ssd = ~(4'b1000 >> bus.scan_idx);
        nxt_d   = act[bus.scan_idx];
        // ~scan_idx == 3 - scan_idx: digit 0 is enabled by digit_en[3].
        if (!bus.digit_en[~bus.scan_idx]) begin
            nxt_ssd = 4'b1111;
            nxt_d   = 8'hFF;
        end
`ifdef SSD_SCAN_BLANK_EN
        if (slot_cnt < CNT_W'(BLANK_CYC)) begin
            nxt_ssd = 4'b1111;
            nxt_d   = 8'hFF;
        end
`endif
    end

    // Scan timing, double-buffer transfer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt       <= '0;
            bus.scan_idx   <= 2'd0;
            pending        <= 1'b0;
            shadow         <= {4{8'hFF}};
            act            <= {4{8'hFF}};
            bus.ssd        <= 4'b1111;
            bus.D          <= 8'hFF;
            bus.frame_tick <= 1'b0;
            bus.load_ack   <= 1'b0;
        end else begin
            bus.frame_tick <= 1'b0;
            bus.load_ack   <= 1'b0;
            bus.ssd        <= nxt_ssd;
            bus.D          <= nxt_d;

            if (slot_wrap) begin
                slot_cnt     <= '0;
                bus.scan_idx <= bus.scan_idx + 2'd1;
            end else begin
                slot_cnt     <= slot_cnt + CNT_W'(1);
            end

            if (frame_end) begin
                bus.frame_tick <= 1'b1;
                // A load on the boundary itself bypasses the shadow and wins.
                if (bus.load) begin
                    act          <= {bus.q_4, bus.q_5, bus.q_6, bus.q_7};
                    pending      <= 1'b0;
                    bus.load_ack <= 1'b1;
                end else if (pending) begin
                    act          <= shadow;
                    pending      <= 1'b0;
                    bus.load_ack <= 1'b1;
                end
            end else if (bus.load) begin
                shadow  <= {bus.q_4, bus.q_5, bus.q_6, bus.q_7};
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed scoreboard bench for ssd_scan_ctrl with
// SCAN_DIV=4, BLANK_CYC=1.
module tb_ssd_scan_ctrl;

    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned BLANK_CYC = 1;
    localparam int unsigned FRAME     = 4 * SCAN_DIV;

    typedef struct packed {
        logic [3:0] ssd;
        logic [7:0] d;
    } slot_t;

    logic clk = 1'b0;
    logic rst;

    ssd_scan_if bus ();

    ssd_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    slot_t exp_q[$];
    int    ack_q[$];
    int    cyc;
    int    n_assert;
    int    n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Queue the four expected slots of one displayed frame.
    task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3,
                              input logic [3:0] en);
        logic [3:0] sel [4];
        logic [7:0] dv  [4];
        slot_t      s;
        sel[0] = 4'b0111; sel[1] = 4'b1011; sel[2] = 4'b1101; sel[3] = 4'b1110;
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        for (int i = 0; i < 4; i++) begin
            if (en[3 - i]) begin
                s.ssd = sel[i];
                s.d   = dv[i];
            end else begin
                s.ssd = 4'b1111;
                s.d   = 8'hFF;
            end
            exp_q.push_back(s);
        end
    endtask

    // Advance one clock and check timing, pulses and (mid-slot) the display.
    task automatic tick();
        slot_t e;
        bit    exp_ack;
        @(negedge clk);
        cyc++;
        chk("scan_idx", 32'(bus.scan_idx), 32'((cyc / SCAN_DIV) % 4));
        chk("frame_tick", 32'(bus.frame_tick), 32'(cyc % FRAME == 0));
        exp_ack = (ack_q.size() > 0) && (ack_q[0] == cyc);
        if (exp_ack) void'(ack_q.pop_front());
        chk("load_ack", 32'(bus.load_ack), 32'(exp_ack));
`ifdef SSD_SCAN_BLANK_EN
        if ((cyc - 1) % SCAN_DIV == 0) begin
            chk("blank_ssd", 32'(bus.ssd), 32'(4'b1111));
        end
`endif
        if ((cyc - 1) % SCAN_DIV == 1) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed empty queue expected entry (cycle %0d)", cyc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ssd", 32'(bus.ssd), 32'(e.ssd));
                chk("D", 32'(bus.D), 32'(e.d));
            end
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ssd", 32'(bus.ssd), 32'(4'b1111));
        chk("rst_D", 32'(bus.D), 32'(8'hFF));
        chk("rst_frame_tick", 32'(bus.frame_tick), 32'(0));
        chk("rst_load_ack", 32'(bus.load_ack), 32'(0));
        chk("rst_scan_idx", 32'(bus.scan_idx), 32'(0));
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        cyc          = 0;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.digit_en = 4'b1111;
        bus.q_7      = 8'h00;
        bus.q_6      = 8'h00;
        bus.q_5      = 8'h00;
        bus.q_4      = 8'h00;
        @(negedge clk);
        do_reset();

        // Frame 0: blank patterns; load issued mid-slot 1.
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b1111);
        repeat (5) tick();
        bus.q_7 = 8'hC0; bus.q_6 = 8'hF9; bus.q_5 = 8'hA4; bus.q_4 = 8'hB0;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        ack_q.push_back(16);
        repeat (10) tick();

        // Frame 1 shows the transferred data; boundary load of 92 at its end.
        push_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b1111);
        repeat (15) tick();
        bus.q_7  = 8'h92;
        bus.load = 1'b1;
        ack_q.push_back(32);
        push_frame(8'h92, 8'hF9, 8'hA4, 8'hB0, 4'b1111);
        tick();
        bus.load = 1'b0;

        // Frame 2: two loads, latest wins at the next boundary.
        repeat (3) tick();
        bus.q_7  = 8'h80;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (5) tick();
        bus.q_7  = 8'h90;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        ack_q.push_back(48);
        push_frame(8'h90, 8'hF9, 8'hA4, 8'hB0, 4'b1111);
        repeat (6) tick();

        // Frame 3 shows 90, then frame 4 with digits 1 and 3 disabled.
        repeat (16) tick();
        bus.digit_en = 4'b1010;
        push_frame(8'h90, 8'hF9, 8'hA4, 8'hB0, 4'b1010);
        repeat (16) tick();

        // Frame 5: load pending, then reset mid-slot discards it.
        bus.digit_en = 4'b1111;
        exp_q.push_back(slot_t'{4'b0111, 8'h90});
        exp_q.push_back(slot_t'{4'b1011, 8'hF9});
        repeat (5) tick();
        bus.q_7 = 8'h11; bus.q_6 = 8'h22; bus.q_5 = 8'h33; bus.q_4 = 8'h44;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (2) tick();
        do_reset();

        // Two frames after reset: still blank, no late transfer or ack.
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b1111);
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b1111);
        repeat (32) tick();

        chk("sb_left", 32'(exp_q.size()), 32'(0));
        chk("ack_left", 32'(ack_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected finish by 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000: clk cycles per digit slot; legal range 2 to 2^20.
REQ-002 The block SHALL have parameter BLANK_CYC, default 16: blanking cycles at the start of each slot (used only with SSD_SCAN_BLANK_EN); legal range 0 to SCAN_DIV-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports q_7, q_6, q_5 and q_4, each input, 8 bits: segment patterns (active-low) for digits 0 to 3 respectively.
REQ-006 The block SHALL have port load, input, 1 bit: a 1-cycle request to capture q_7 to q_4 into the shadow registers.
REQ-007 The block SHALL have port digit_en, input, 4 bits: per-digit enable; bit 3 controls digit 0 (q_7) and bit 0 controls digit 3 (q_4).
REQ-008 The block SHALL have port ssd, output, 4 bits: active-low digit select, registered.
REQ-009 The block SHALL have port D, output, 8 bits: active-low segment data, registered.
REQ-010 The block SHALL have port scan_idx, output, 2 bits: index of the digit currently being scanned.
REQ-011 The block SHALL have port frame_tick, output, 1 bit: a 1-cycle pulse on each frame wrap.
REQ-012 The block SHALL have port load_ack, output, 1 bit: a 1-cycle pulse when shadow data becomes active.

Function
REQ-013 slot_cnt SHALL count 0 to SCAN_DIV-1 and wrap to 0.
- On the wrap cycle, scan_idx SHALL increment modulo 4.
REQ-014 When scan_idx goes from 3 to 0 (the frame boundary), frame_tick SHALL be 1 for exactly the following cycle.
REQ-015 ssd and D SHALL be registered from scan_idx and the active registers, giving exactly 1 cycle of latency.
- idx 0 -> ssd=0111, D=act_7; idx 1 -> 1011, act_6; idx 2 -> 1101, act_5; idx 3 -> 1110, act_4.
REQ-016 If the digit_en bit for the current digit is 0, then ssd=1111 and D=8'hFF for that slot; scan timing SHALL be unaffected.
REQ-017 load=1 on a non-boundary cycle SHALL capture q_7 to q_4 into the shadow registers and set pending=1.
- Active registers SHALL be unchanged until the next frame boundary.
REQ-018 At a frame boundary with pending=1, active SHALL be set from shadow, pending SHALL clear, and load_ack SHALL be 1 in the next cycle.
REQ-019 A repeated load while pending=1 SHALL overwrite the shadow registers (latest wins).
- Exactly one load_ack SHALL be produced per boundary transfer.
REQ-020 load=1 on the boundary cycle itself SHALL write q_7 to q_4 directly into active, bypassing shadow.
- Pending SHALL clear and load_ack SHALL pulse the next cycle.
REQ-021 load_ack and frame_tick SHALL never be asserted for more than 1 consecutive cycle.
REQ-022 slot_cnt width SHALL be clog2(SCAN_DIV); the wrap comparison SHALL be exact, with no off-by-one.
- Each slot SHALL last exactly SCAN_DIV cycles.

Reset
REQ-023 rst=1 SHALL set the following values.
- slot_cnt=0, scan_idx=0, pending=0.
- Shadow and active registers = 8'hFF.
- ssd=4'b1111, D=8'hFF, frame_tick=0, load_ack=0.
REQ-024 rst asserted mid-slot or mid-pending SHALL discard any pending load, with no load_ack.
- Scanning SHALL restart at digit 0 on the first cycle after rst deasserts.

Configuration
REQ-025 Macro SSD_SCAN_BLANK_EN defined: while slot_cnt < BLANK_CYC, ssd=1111 and D=8'hFF (ghosting suppression).
- The normal pattern SHALL follow, still with 1-cycle latency.
REQ-026 Macro SSD_SCAN_BLANK_EN undefined: no blanking; BLANK_CYC SHALL be ignored and no blanking logic synthesized.

Verification (SCAN_DIV=4, BLANK_CYC=1)
REQ-027 Reset release with digit_en=1111 -> ssd sequence 0111,1011,1101,1110, each held 4 cycles, D=FF throughout; frame_tick=1 once per 16 cycles.
REQ-028 load=1 mid-slot 1 with q_7=C0, q_6=F9, q_5=A4, q_4=B0 -> D stays FF until the frame boundary.
- load_ack=1 for 1 cycle, then the next frame shows C0, F9, A4, B0.
REQ-029 load on the boundary cycle with q_7=92 -> digit 0 shows 92 in the immediately following slot; load_ack=1 once.
REQ-030 Two loads in one frame, q_7=80 then q_7=90 -> the next frame shows 90; exactly one load_ack.
REQ-031 digit_en=1010 -> slots 1 and 3 show ssd=1111, D=FF; slots 0 and 2 are normal; period unchanged.
REQ-032 rst during pending -> no load_ack; ssd=1111, D=FF.
- With SSD_SCAN_BLANK_EN defined, the first cycle of every slot shows ssd=1111.
